// File: rtl/sdram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arbiter_pkg
// Shared definitions for the SDRAM command arbiter:
//   - default data/address widths of the sdram_ctrl command interface
//   - default starvation limit and starvation counter width
//   - FSM state encoding
// -----------------------------------------------------------------------------
package sdram_arbiter_pkg;

  localparam int unsigned SDRAM_DATA_NBIT = 32;
  localparam int unsigned SDRAM_ADDR_NBIT = 24;

  // Consecutive read grants allowed while a write is waiting.
  localparam int unsigned STARVE_MAX_DEF  = 8;
  // Wide enough for the full 1..255 STARVE_MAX range.
  localparam int unsigned STARVE_CNT_NBIT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_GUARD = 3'd2,
    WR_WAIT  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_GUARD = 3'd5,
    RD_WAIT  = 3'd6
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_starve_cnt.sv
// -----------------------------------------------------------------------------
// sdram_arb_starve_cnt
// Saturating counter of read grants given while a write is pending.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear to 0 (takes priority over inc)
//   inc        : increment, saturates at MAX
//   at_max     : counter equals MAX; the writer wins the next arbitration
// -----------------------------------------------------------------------------
module sdram_arb_starve_cnt
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam logic [STARVE_CNT_NBIT-1:0] MAX_V = STARVE_CNT_NBIT'(MAX);

  logic [STARVE_CNT_NBIT-1:0] cnt;

  // NOTE: registers are written with <= so every flop samples pre-edge values;
  // blocking = here would create order-dependent simulation behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares the sdram_ctrl read/write command interface between the waveform
// loader (writer) and the playback prefetcher (reader). Reads have priority;
// after STARVE_MAX consecutive read grants with a write pending, the write
// wins once. Each access is issue strobe -> guard cycle -> wait on status.
//
// Ports:
//   clk, rst_n                        : mclk, synchronous active-low reset
//   wr_req/wr_addr/wr_data/wr_ack     : writer handshake (ack = 1-cycle pulse)
//   rd_req/rd_addr/rd_ack             : reader handshake (ack = 1-cycle pulse)
//   rd_data/rd_dv                     : registered read data + 1-cycle valid
//   sdram_wren/waddr/wdata/wstatus    : write command interface to sdram_ctrl
//   sdram_rd/raddr/rdata/rdv/rstatus  : read command interface to sdram_ctrl
//   busy                              : FSM not in IDLE
//   err                               : sticky watchdog error
//
// Optional feature, macro SDRAM_ARB_TIMEOUT_EN: a watchdog aborts a WAIT state
// after TIMEOUT cycles and sets err. Without the macro err is tied 0 and the
// WAIT states wait indefinitely.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned DATA_NBIT  = SDRAM_DATA_NBIT,
  parameter int unsigned ADDR_NBIT  = SDRAM_ADDR_NBIT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [ADDR_NBIT-1:0] wr_addr,
  input  logic [DATA_NBIT-1:0] wr_data,
  output logic                 wr_ack,
  input  logic                 rd_req,
  input  logic [ADDR_NBIT-1:0] rd_addr,
  output logic                 rd_ack,
  output logic [DATA_NBIT-1:0] rd_data,
  output logic                 rd_dv,
  output logic                 sdram_wren,
  output logic [ADDR_NBIT-1:0] sdram_waddr,
  output logic [DATA_NBIT-1:0] sdram_wdata,
  input  logic                 sdram_wstatus,
  output logic                 sdram_rd,
  output logic [ADDR_NBIT-1:0] sdram_raddr,
  input  logic [DATA_NBIT-1:0] sdram_rdata,
  input  logic                 sdram_rdv,
  input  logic                 sdram_rstatus,
  output logic                 busy,
  output logic                 err
);

  arb_state_t state, state_nxt;

  logic arb_en;        // arbitration point this cycle
  logic grant_rd;
  logic grant_wr;
  logic starve_at_max;
  logic rdv_seen;      // first sdram_rdv of the current read already taken
  logic capture;       // forward sdram_rdata this cycle
  logic timeout;       // watchdog abort this cycle
  logic wd_expired;

  // ---------------------------------------------------------------------------
  // Next-state logic. A WAIT state whose exit condition holds re-arbitrates in
  // the same cycle, so back-to-back accesses are spaced ISSUE/GUARD/WAIT =
  // 3 cycles with no extra IDLE cycle in between.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE:     arb_en = 1'b1;
      WR_ISSUE: state_nxt = WR_GUARD;
      WR_GUARD: state_nxt = WR_WAIT;
      WR_WAIT: begin
        if (!sdram_wstatus) arb_en  = 1'b1;
        else                timeout = wd_expired;
      end
      RD_ISSUE: state_nxt = RD_GUARD;
      RD_GUARD: state_nxt = RD_WAIT;
      RD_WAIT: begin
        // Data valid and status idle may arrive in either order.
        if ((rdv_seen || sdram_rdv) && !sdram_rstatus) arb_en  = 1'b1;
        else                                           timeout = wd_expired;
      end
      default:  state_nxt = IDLE;
    endcase

    grant_rd = arb_en && rd_req && !(wr_req && starve_at_max);
    grant_wr = arb_en && wr_req && !grant_rd;

    if (grant_rd)               state_nxt = RD_ISSUE;
    else if (grant_wr)          state_nxt = WR_ISSUE;
    else if (arb_en || timeout) state_nxt = IDLE;
  end

  // Only the first sdram_rdv of an access, and never one from an aborted read.
  assign capture = sdram_rdv && !rdv_seen && !timeout &&
                   (state == RD_GUARD || state == RD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sdram_waddr <= '0;
      sdram_wdata <= '0;
      sdram_raddr <= '0;
      rd_data     <= '0;
      rd_dv       <= 1'b0;
      rdv_seen    <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_dv <= capture;
      if (capture) begin
        rd_data  <= sdram_rdata;
        rdv_seen <= 1'b1;
      end
      if (grant_wr) begin
        sdram_waddr <= wr_addr;
        sdram_wdata <= wr_data;
      end
      // Placed after the capture so a grant issued in the exit cycle of a
      // read starts the new access with a clean flag.
      if (grant_rd) begin
        sdram_raddr <= rd_addr;
        rdv_seen    <= 1'b0;
      end
    end
  end

  sdram_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (grant_wr || (arb_en && !wr_req)),
    .inc    (grant_rd && wr_req),
    .at_max (starve_at_max)
  );

  assign sdram_wren = (state == WR_ISSUE);
  assign wr_ack     = (state == WR_ISSUE);
  assign sdram_rd   = (state == RD_ISSUE);
  assign rd_ack     = (state == RD_ISSUE);
  assign busy       = (state != IDLE);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned WD_NBIT = 10;
  localparam logic [WD_NBIT-1:0] WD_LAST = WD_NBIT'(TIMEOUT - 1);

  logic [WD_NBIT-1:0] wd_cnt;
  logic               err_q;

  // Counts consecutive cycles spent in a WAIT state; restarts on any exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == WR_WAIT || state == RD_WAIT) && state_nxt == state) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (timeout) err_q <= 1'b1;
    end
  end

  assign wd_expired = (wd_cnt == WD_LAST);
  assign err        = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter with a small sdram_ctrl model. Stimulus
// pushes the expected strobes and read data into queues; a monitor pops and
// compares whenever the DUT issues a strobe or asserts rd_dv.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int unsigned DN = 32;
  localparam int unsigned AN = 24;
`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int unsigned TO = 20;
`else
  localparam int unsigned TO = 1023;
`endif

  logic          clk;
  logic          rst_n;
  logic          wr_req, rd_req;
  logic [AN-1:0] wr_addr, rd_addr;
  logic [DN-1:0] wr_data;
  logic          wr_ack, rd_ack, rd_dv;
  logic [DN-1:0] rd_data;
  logic          sdram_wren, sdram_rd;
  logic [AN-1:0] sdram_waddr, sdram_raddr;
  logic [DN-1:0] sdram_wdata, sdram_rdata;
  logic          sdram_wstatus, sdram_rdv, sdram_rstatus;
  logic          busy, err;

  sdram_arbiter #(
    .DATA_NBIT  (DN),
    .ADDR_NBIT  (AN),
    .STARVE_MAX (8),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_dv         (rd_dv),
    .sdram_wren    (sdram_wren),
    .sdram_waddr   (sdram_waddr),
    .sdram_wdata   (sdram_wdata),
    .sdram_wstatus (sdram_wstatus),
    .sdram_rd      (sdram_rd),
    .sdram_raddr   (sdram_raddr),
    .sdram_rdata   (sdram_rdata),
    .sdram_rdv     (sdram_rdv),
    .sdram_rstatus (sdram_rstatus),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_wr;
    logic [AN-1:0] addr;
    logic [DN-1:0] data;
  } strobe_t;

  strobe_t       exp_strobe[$];
  logic [DN-1:0] exp_rd[$];
  int            checks      = 0;
  int            errors      = 0;
  int            strobes_seen = 0;

  // Model controls
  int   wbusy_cycles = 0;
  int   rd_lat       = 1;
  logic wstuck       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DN-1:0] model_data(input logic [AN-1:0] a);
    if (a == 24'h000020) return 32'h12345678;
    return {8'hC5, a};
  endfunction

  // ---------------------------------------------------------------------------
  // sdram_ctrl model: wstatus high wbusy_cycles cycles after a write strobe;
  // sdram_rdv rd_lat cycles after a read strobe, rstatus high until then.
  // ---------------------------------------------------------------------------
  initial begin
    int            wcnt, rcnt;
    logic          rpend, w_s, r_s;
    logic [AN-1:0] ra, ra_l;
    wcnt = 0; rcnt = 0; rpend = 1'b0; ra_l = '0;
    sdram_wstatus = 1'b0; sdram_rstatus = 1'b0; sdram_rdv = 1'b0; sdram_rdata = '0;
    forever begin
      @(negedge clk);
      w_s = (sdram_wren === 1'b1);
      r_s = (sdram_rd === 1'b1);
      ra  = sdram_raddr;
      @(posedge clk); #1;
      if (w_s) wcnt = wbusy_cycles;
      sdram_wstatus = wstuck || (wcnt > 0);
      if (wcnt > 0) wcnt--;
      if (r_s) begin rcnt = rd_lat; rpend = 1'b1; ra_l = ra; end
      sdram_rdv = 1'b0;
      if (rpend) begin
        rcnt--;
        sdram_rstatus = 1'b1;
        if (rcnt == 0) begin
          sdram_rdv   = 1'b1;
          sdram_rdata = model_data(ra_l);
          rpend       = 1'b0;
        end
      end else begin
        sdram_rstatus = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    strobe_t       s;
    logic [DN-1:0] e;
    logic          prev_rdv;
    prev_rdv = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_dv === 1'b1) begin
        check("rd_dv_latency", prev_rdv, 1);
        if (exp_rd.size() == 0) begin
          check("rd_dv_unexpected", rd_dv, 0);
        end else begin
          e = exp_rd.pop_front();
          check("rd_data", rd_data, e);
        end
      end
      if (sdram_wren === 1'b1 || sdram_rd === 1'b1) begin
        strobes_seen++;
        if (exp_strobe.size() == 0) begin
          check("strobe_unexpected", {sdram_wren, sdram_rd}, 0);
        end else begin
          s = exp_strobe.pop_front();
          check("strobe_wren", sdram_wren, s.is_wr);
          check("strobe_rd", sdram_rd, !s.is_wr);
          if (s.is_wr) begin
            check("wr_ack", wr_ack, 1);
            check("sdram_waddr", sdram_waddr, s.addr);
            check("sdram_wdata", sdram_wdata, s.data);
          end else begin
            check("rd_ack", rd_ack, 1);
            check("sdram_raddr", sdram_raddr, s.addr);
          end
        end
      end
      prev_rdv = (sdram_rdv === 1'b1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input bit want_wr, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((want_wr ? sdram_wren : sdram_rd) === 1'b1) && n < 64);
    check(name, want_wr ? sdram_wren : sdram_rd, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (busy !== 1'b0 && n < 200);
    check(name, busy, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n, rd_i, wr_i, base, dv_cnt, last;
    rst_n = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_ctrl", {wr_ack, rd_ack, rd_dv, sdram_wren, sdram_rd, busy, err}, 0);
    check("reset_bus", {sdram_waddr, sdram_raddr, sdram_wdata, rd_data}, 0);

    // Single write, controller busy for 5 cycles
    step();
    wbusy_cycles = 5;
    exp_strobe.push_back('{1'b1, 24'h000010, 32'hA5A5A5A5});
    wr_addr = 24'h000010; wr_data = 32'hA5A5A5A5; wr_req = 1'b1;
    wait_strobe(1'b1, "wr_single_strobe");
    step(); wr_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (sdram_wstatus && n < 32);
    check("wr_wstatus_fall", sdram_wstatus, 0);
    check("wr_busy_at_fall", busy, 1);
    @(negedge clk);
    check("wr_busy_after_fall", busy, 0);

    // Single read, data 4 cycles after the strobe
    step();
    rd_lat = 4;
    exp_strobe.push_back('{1'b0, 24'h000020, 32'h0});
    exp_rd.push_back(32'h12345678);
    rd_addr = 24'h000020; rd_req = 1'b1;
    wait_strobe(1'b0, "rd_single_strobe");
    step(); rd_req = 1'b0;
    wait_idle("rd_single_idle");

    // Contention: both held high, expect R x8, W, R x8, W, R x8, W
    step();
    rd_lat = 1; wbusy_cycles = 0;
    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < 8; r++) begin
        exp_strobe.push_back('{1'b0, 24'h000100 + 24'(g * 8 + r), 32'h0});
        exp_rd.push_back(32'hC5000100 + 32'(g * 8 + r));
      end
      exp_strobe.push_back('{1'b1, 24'h000200 + 24'(g), 32'hBEEF0000 + 32'(g)});
    end
    base = strobes_seen;
    rd_i = 0; wr_i = 0; n = 0;
    rd_addr = 24'h000100; wr_addr = 24'h000200; wr_data = 32'hBEEF0000;
    rd_req = 1'b1; wr_req = 1'b1;
    while ((rd_i < 24 || wr_i < 3) && n < 400) begin
      @(negedge clk); n++;
      if (rd_ack) rd_i++;
      if (wr_ack) wr_i++;
      step();
      rd_req  = (rd_i < 24);
      rd_addr = 24'h000100 + 24'(rd_i);
      wr_req  = (wr_i < 3);
      wr_addr = 24'h000200 + 24'(wr_i);
      wr_data = 32'hBEEF0000 + 32'(wr_i);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    wait_idle("contention_idle");
    check("contention_strobes", strobes_seen - base, 27);

    // Reset in RD_WAIT, late sdram_rdv must be ignored
    step();
    rd_lat = 6;
    exp_strobe.push_back('{1'b0, 24'h000030, 32'h0});
    rd_addr = 24'h000030; rd_req = 1'b1;
    wait_strobe(1'b0, "rst_rd_strobe");
    step(); rd_req = 1'b0;
    step();
    check("rst_in_rd_wait", busy, 1);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rst_mid_ctrl", {wr_ack, rd_ack, rd_dv, sdram_wren, sdram_rd, busy, err}, 0);
    check("rst_mid_bus", {sdram_waddr, sdram_raddr, sdram_wdata, rd_data}, 0);
    step();
    rst_n = 1'b1;
    dv_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_dv !== 1'b0) dv_cnt++;
    end
    check("rst_no_rd_dv", dv_cnt, 0);

    // Write after reset is served normally
    step();
    wbusy_cycles = 2;
    exp_strobe.push_back('{1'b1, 24'h000040, 32'h0BADF00D});
    wr_addr = 24'h000040; wr_data = 32'h0BADF00D; wr_req = 1'b1;
    wait_strobe(1'b1, "post_rst_wr_strobe");
    step(); wr_req = 1'b0;
    wait_idle("post_rst_wr_idle");

    // Back-to-back writes, status never busy: strobes exactly 3 cycles apart
    step();
    wbusy_cycles = 0;
    for (int i = 0; i < 4; i++)
      exp_strobe.push_back('{1'b1, 24'h000050 + 24'(i), 32'h10000000 + 32'(i)});
    wr_i = 0; n = 0; last = 0;
    wr_addr = 24'h000050; wr_data = 32'h10000000; wr_req = 1'b1;
    while (wr_i < 4 && n < 200) begin
      @(negedge clk); n++;
      if (wr_ack) begin
        if (wr_i > 0) check("b2b_spacing", n - last, 3);
        last = n;
        wr_i++;
      end
      step();
      wr_req  = (wr_i < 4);
      wr_addr = 24'h000050 + 24'(wr_i);
      wr_data = 32'h10000000 + 32'(wr_i);
    end
    wr_req = 1'b0;
    check("b2b_count", wr_i, 4);
    wait_idle("b2b_idle");

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Watchdog: wstatus stuck high, abort after 20 WAIT cycles
    step();
    wstuck = 1'b1;
    exp_strobe.push_back('{1'b1, 24'h000060, 32'h600D600D});
    wr_addr = 24'h000060; wr_data = 32'h600D600D; wr_req = 1'b1;
    wait_strobe(1'b1, "to_wr_strobe");
    step(); wr_req = 1'b0;
    repeat (20) @(negedge clk);
    check("to_err_before", err, 0);
    check("to_busy_before", busy, 1);
    @(negedge clk);
    check("to_err_set", err, 1);
    check("to_busy_after", busy, 0);
    step();
    wstuck = 1'b0;
    rd_lat = 2;
    exp_strobe.push_back('{1'b0, 24'h000070, 32'h0});
    exp_rd.push_back(32'hC5000070);
    rd_addr = 24'h000070; rd_req = 1'b1;
    wait_strobe(1'b0, "to_rd_strobe");
    step(); rd_req = 1'b0;
    wait_idle("to_rd_idle");
    check("to_err_sticky", err, 1);
`endif

    repeat (4) @(negedge clk);
    check("strobe_queue_empty", exp_strobe.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1);
  end

endmodule
